// File: rtl/uart_mem_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the UART-driven
// memory master.
package uart_mem_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WR,
    ST_RD,
    ST_RSP
  } state_t;

endpackage

// File: rtl/uart_mem_master_if.sv
// CPU-side memory port as seen by the UART memory master.
// Handshake: the master holds vaddr/data/byteena/memWE constant while memWait
// is high; a request is accepted on the first clock edge with memWait low.
interface uart_mem_master_if;

  logic [31:0] vaddr;
  logic [31:0] data;
  logic [3:0]  byteena;
  logic        memWE;
  logic        memWait;
  logic [31:0] q;

  modport master (
    output vaddr, data, byteena, memWE,
    input  memWait, q
  );

  modport slave (
    input  vaddr, data, byteena, memWE,
    output memWait, q
  );

endinterface

// File: rtl/uart_byte_sender.sv
// Shifts out 1 or 4 response bytes, LSB first, one txWE pulse per byte,
// waiting for txBusy low and a post-pulse guard gap before each byte.
module uart_byte_sender #(
  parameter int TX_GAP = 2
) (
  input  logic        clock,
  input  logic        RST,
  input  logic        load,
  input  logic [2:0]  count,
  input  logic [31:0] word,
  input  logic        txBusy,
  output logic [7:0]  txData,
  output logic        txWE,
  output logic        done
);

  localparam int GW = $clog2(TX_GAP + 2);

  logic [31:0]   shift;
  logic [2:0]    remaining;
  logic [GW-1:0] gap;
  logic          fire;

  // The gap covers the transmitter's delay in raising txBusy after a pulse.
  assign fire = (remaining != '0) && !txBusy && (gap == '0);

  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      shift     <= '0;
      remaining <= '0;
      gap       <= '0;
      txData    <= '0;
      txWE      <= 1'b0;
      done      <= 1'b0;
    end else begin
      txWE <= fire;
      done <= fire && (remaining == 3'd1);
      if (load) begin
        shift     <= word;
        remaining <= count;
      end else if (fire) begin
        txData    <= shift[7:0];
        shift     <= {8'h00, shift[31:8]};
        remaining <= remaining - 3'd1;
      end
      if (fire) begin
        gap <= GW'(TX_GAP);
      end else if (gap != '0) begin
        gap <= gap - GW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_mem_master.sv
// Parses 'W'/'R' command frames from a UART byte stream, performs one memory
// transaction per frame and returns ACK, NAK or read data as bytes.
module uart_mem_master
  import uart_mem_pkg::*;
#(
  parameter int READ_LATENCY = 3,
  parameter int TIMEOUT      = 1000000,
  parameter int TX_GAP       = 2
) (
  input  logic               clock,
  input  logic               RST,
  input  logic [7:0]         rxData,
  input  logic               rxValid,
  output logic [7:0]         txData,
  output logic               txWE,
  input  logic               txBusy,
  uart_mem_master_if.master  mem,
  output logic               busActive,
  output logic               errOverrun,
  output state_t             state_dbg
);

  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, state_nxt;
  logic          is_write;
  logic [1:0]    idx;
  logic [31:0]   addr, wdata;
  logic [31:0]   vaddr_r, data_r;
  logic [LW-1:0] lat_cnt;
  logic [TW-1:0] to_cnt;
  logic          load, done;
  logic [2:0]    load_count;
  logic [31:0]   load_word;
  logic          timed_out;

  assign timed_out = !rxValid && (to_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    load_count = 3'd1;
    load_word  = 32'h0;
    unique case (state)
      ST_IDLE: if (rxValid) begin
        if (rxData == OP_WRITE || rxData == OP_READ) begin
          state_nxt = ST_ADDR;
        end else begin
          state_nxt = ST_RSP;
          load      = 1'b1;
          load_word = {24'h0, RSP_NAK};
        end
      end
      ST_ADDR: begin
        if (rxValid && idx == 2'd3) state_nxt = is_write ? ST_DATA : ST_RD;
        else if (timed_out)         state_nxt = ST_IDLE;
      end
      ST_DATA: begin
        if (rxValid && idx == 2'd3) state_nxt = ST_WR;
        else if (timed_out)         state_nxt = ST_IDLE;
      end
      ST_WR: if (!mem.memWait) begin
        state_nxt = ST_RSP;
        load      = 1'b1;
        load_word = {24'h0, RSP_ACK};
      end
      // q is sampled by the sender's load on the final un-stalled count.
      ST_RD: if (!mem.memWait && lat_cnt == LW'(READ_LATENCY)) begin
        state_nxt  = ST_RSP;
        load       = 1'b1;
        load_count = 3'd4;
        load_word  = mem.q;
      end
      ST_RSP: if (done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      is_write   <= 1'b0;
      idx        <= '0;
      addr       <= '0;
      wdata      <= '0;
      vaddr_r    <= '0;
      data_r     <= '0;
      lat_cnt    <= '0;
      to_cnt     <= '0;
      errOverrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rxValid && (state == ST_WR || state == ST_RD || state == ST_RSP))
        errOverrun <= 1'b1;

      unique case (state)
        ST_IDLE: if (rxValid) begin
          is_write <= (rxData == OP_WRITE);
          idx      <= '0;
        end
        ST_ADDR: if (rxValid) begin
          addr[{idx, 3'b000} +: 8] <= rxData;
          idx <= idx + 2'd1;
          if (idx == 2'd3 && !is_write) vaddr_r <= {rxData, addr[23:0]};
        end
        ST_DATA: if (rxValid) begin
          wdata[{idx, 3'b000} +: 8] <= rxData;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            vaddr_r <= addr;
            data_r  <= {rxData, wdata[23:0]};
          end
        end
        default: ;
      endcase

      if ((state == ST_ADDR || state == ST_DATA) && !rxValid) to_cnt <= to_cnt + TW'(1);
      else                                                    to_cnt <= '0;

      if (state != ST_RD)     lat_cnt <= '0;
      else if (!mem.memWait)  lat_cnt <= lat_cnt + LW'(1);
    end
  end

  assign mem.vaddr   = vaddr_r;
  assign mem.data    = data_r;
  assign mem.memWE   = (state == ST_WR);
  assign mem.byteena = (state == ST_WR) ? 4'hF : 4'h0;
  assign busActive   = (state == ST_WR) || (state == ST_RD);
  assign state_dbg   = state;

  uart_byte_sender #(.TX_GAP(TX_GAP)) u_sender (
    .clock  (clock),
    .RST    (RST),
    .load   (load),
    .count  (load_count),
    .word   (load_word),
    .txBusy (txBusy),
    .txData (txData),
    .txWE   (txWE),
    .done   (done)
  );

endmodule

// File: tb/tb_uart_mem_master.sv
// Directed bench for uart_mem_master: write, read, stall, NAK, timeout,
// overrun and asynchronous reset, against a UART TX model and a 3-stage memory.
module tb_uart_mem_master;
  import uart_mem_pkg::*;

  localparam int READ_LATENCY = 3;
  localparam int TIMEOUT      = 40;
  localparam int TX_GAP       = 2;
  localparam int BUSY_LEN     = 5;

  // clock / reset
  logic   clock = 1'b0;
  logic   RST = 1'b1;
  logic [7:0] rxData = 8'h00;
  logic   rxValid = 1'b0;
  logic [7:0] txData;
  logic   txWE;
  logic   txBusy = 1'b0;
  logic   busActive, errOverrun;
  state_t state_dbg;

  uart_mem_master_if mem();

  uart_mem_master #(
    .READ_LATENCY (READ_LATENCY),
    .TIMEOUT      (TIMEOUT),
    .TX_GAP       (TX_GAP)
  ) dut (
    .clock      (clock),
    .RST        (RST),
    .rxData     (rxData),
    .rxValid    (rxValid),
    .txData     (txData),
    .txWE       (txWE),
    .txBusy     (txBusy),
    .mem        (mem.master),
    .busActive  (busActive),
    .errOverrun (errOverrun),
    .state_dbg  (state_dbg)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // UART transmitter model: busy for BUSY_LEN cycles after each pulse
  int busy_cnt = 0;
  int busy_violations = 0;
  always @(negedge clock) begin
    if (txWE) begin
      got_q.push_back(txData);
      if (txBusy) busy_violations++;
      busy_cnt = BUSY_LEN;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    txBusy = (busy_cnt != 0);
  end

  // memory model: registered address, sync RAM, registered q
  logic [31:0] bmem [logic [31:0]];
  int          wr_cnt = 0, we_cycles = 0, unstable = 0;
  logic [31:0] wr_addr = 0, wr_data = 0, we_addr0 = 0, we_data0 = 0;
  logic [3:0]  wr_be = 0;
  logic        we_prev = 1'b0;
  logic [32:0] s1 = 0, s2 = 0, s3 = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : 32'h0;
  endfunction

  always @(negedge clock) begin
    if (mem.memWE) begin
      we_cycles++;
      if (we_prev && (mem.vaddr !== we_addr0 || mem.data !== we_data0 || mem.byteena !== 4'hF))
        unstable++;
      if (!we_prev) begin
        we_addr0 = mem.vaddr;
        we_data0 = mem.data;
      end
      if (!mem.memWait) begin
        wr_cnt++;
        wr_addr = mem.vaddr;
        wr_data = mem.data;
        wr_be   = mem.byteena;
        bmem[mem.vaddr] = mem.data;
      end
    end
    we_prev = mem.memWE;
    if (!mem.memWait) begin
      mem.q = s3[32] ? rd(s3[31:0]) : 32'h0;
      s3 = s2;
      s2 = s1;
      s1 = {busActive && !mem.memWE, mem.vaddr};
    end
  end

  // driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxData  = b;
    rxValid = 1'b1;
    @(posedge clock);
    #1;
    rxValid = 1'b0;
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(OP_WRITE);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(OP_READ);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
  endtask

  task automatic wait_state(input state_t st, input int budget, input string tag);
    for (int c = 0; c < budget && state_dbg != st; c++) @(negedge clock);
    check(tag, state_dbg, st);
  endtask

  // scoreboard: expected response bytes, LSB first
  task automatic expect_rsp(input int n, input logic [31:0] word, input string tag);
    logic [7:0] g, e;
    for (int i = 0; i < n; i++) exp_q.push_back(word[8*i +: 8]);
    for (int c = 0; c < 300 && got_q.size() < n; c++) @(negedge clock);
    check({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      check(tag, {24'h0, g}, {24'h0, e});
    end
    exp_q.delete();
  endtask

  int wr0;

  initial begin
    mem.memWait = 1'b0;
    #2 RST = 1'b0;
    #1;
    check("rst_txWE",       txWE, 0);
    check("rst_memWE",      mem.memWE, 0);
    check("rst_busActive",  busActive, 0);
    check("rst_errOverrun", errOverrun, 0);
    check("rst_state",      state_dbg, ST_IDLE);
    check("rst_vaddr",      mem.vaddr, 0);
    check("rst_byteena",    mem.byteena, 0);
    check("rst_txData",     txData, 0);
    tick(3);
    RST = 1'b1;
    tick(2);

    // write 0xDEADBEEF to 0x100
    send_write(32'h0000_0100, 32'hDEAD_BEEF);
    expect_rsp(1, 32'h06, "wr_ack");
    check("wr_count", wr_cnt, 1);
    check("wr_addr",  wr_addr, 32'h0000_0100);
    check("wr_data",  wr_data, 32'hDEAD_BEEF);
    check("wr_be",    wr_be, 4'hF);
    check("wr_cycles", we_cycles, 1);
    tick(8);
    check("wr_no_extra", got_q.size(), 0);
    check("wr_idle",     state_dbg, ST_IDLE);
    check("vaddr_hold",  mem.vaddr, 32'h0000_0100);
    check("bus_idle",    busActive, 0);

    // read back 0x100
    send_read(32'h0000_0100);
    expect_rsp(4, 32'hDEAD_BEEF, "rd");
    check("rd_busy_ok", busy_violations, 0);
    check("rd_no_write", wr_cnt, 1);

    // write stalled for 5 cycles
    we_cycles = 0;
    mem.memWait = 1'b1;
    send_write(32'h0000_0202, 32'h1122_3344);
    repeat (5) @(posedge clock);
    #1;
    check("stall_memWE_held", mem.memWE, 1);
    check("stall_no_commit",  wr_cnt, 1);
    mem.memWait = 1'b0;
    expect_rsp(1, 32'h06, "stall_ack");
    check("stall_cycles",   we_cycles, 6);
    check("stall_stable",   unstable, 0);
    check("stall_commits",  wr_cnt, 2);
    check("stall_addr",     wr_addr, 32'h0000_0202);
    check("stall_data",     wr_data, 32'h1122_3344);

    // bad opcode, then a normal read
    send_byte(8'h41);
    expect_rsp(1, 32'h15, "nak");
    tick(2);
    check("nak_idle", state_dbg, ST_IDLE);
    send_read(32'h0000_0202);
    expect_rsp(4, 32'h1122_3344, "rd_after_nak");

    // timeout on a partial frame
    tick(8);
    wr0 = wr_cnt;
    send_byte(OP_WRITE);
    send_byte(8'h00);
    send_byte(8'h01);
    tick(TIMEOUT + 5);
    check("to_idle",     state_dbg, ST_IDLE);
    check("to_no_tx",    got_q.size(), 0);
    check("to_no_write", wr_cnt, wr0);
    send_read(32'h0000_0100);
    expect_rsp(4, 32'hDEAD_BEEF, "rd_after_to");

    // overrun during response
    tick(8);
    send_read(32'h0000_0100);
    wait_state(ST_RSP, 50, "ovr_in_rsp");
    send_byte(8'h33);
    check("ovr_flag", errOverrun, 1);
    expect_rsp(4, 32'hDEAD_BEEF, "ovr_rd");
    tick(5);
    check("ovr_idle",   state_dbg, ST_IDLE);
    check("ovr_sticky", errOverrun, 1);

    // asynchronous reset in the middle of a read
    send_read(32'h0000_0100);
    check("mid_rd_state", state_dbg, ST_RD);
    RST = 1'b0;
    #1;
    check("arst_busActive",  busActive, 0);
    check("arst_txWE",       txWE, 0);
    check("arst_errOverrun", errOverrun, 0);
    check("arst_state",      state_dbg, ST_IDLE);
    check("arst_memWE",      mem.memWE, 0);
    tick(2);
    RST = 1'b1;
    tick(10);
    check("arst_no_tx", got_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_mem_master.md
Name: uart_mem_master

Overview:
- Bus initiator that turns a command byte stream from a UART receiver into read/write transactions on the CPU-side memory port (vaddr/data/byteena/memWE/q/memWait) of the memory subsystem.
- Responses go back as a byte stream to a UART transmitter.
- Used for program loading and debug peek/poke while the CPU is held off the port. busActive drives the port mux select.

Parameters:
- READ_LATENCY, 3: cycles from vaddr valid to q valid on the memory port (registered address, synchronous RAM, registered q).
- TIMEOUT, 1000000: idle clock cycles between bytes of one frame before the parser aborts.
- TX_GAP, 2: cycles after a txWE pulse during which txBusy is ignored.

Ports:
- clock  in  1  system clock
- RST  in  1  reset, asynchronous, active-low
- rxData  in  8  received byte
- rxValid  in  1  one-cycle strobe, rxData valid
- txData  out  8  byte to transmit
- txWE  out  1  one-cycle transmit strobe
- txBusy  in  1  transmitter busy
- vaddr  out  32  memory address
- data  out  32  write data
- byteena  out  4  byte enables
- memWE  out  1  write enable
- memWait  in  1  memory stall, hold request while high
- q  in  32  read data
- busActive  out  1  high while a memory transaction is in flight
- errOverrun  out  1  sticky: a byte was dropped

Behaviour:
- Reset (RST low, async): state IDLE. All outputs 0, errOverrun 0, all counters 0.
- Frame format, multi-byte fields little-endian:
  - 0x57 'W', A0..A3, D0..D3 -> write; response 0x06.
  - 0x52 'R', A0..A3 -> read; response Q0..Q3.
  - Any other first byte -> response 0x15 (NAK), back to IDLE.
- States: IDLE, ADDR, DATA, WR, RD, RSP.
  - IDLE: rxValid with 0x57/0x52 -> ADDR, opcode latched, byte index 0.
  - ADDR: 4 bytes shifted into addr[8i+7:8i]. After the 4th byte: W -> DATA, R -> RD.
  - DATA: 4 bytes into wdata. After the 4th byte -> WR.
  - WR: vaddr=addr, data=wdata, byteena=4'hF, memWE=1, busActive=1.
    - Held while memWait=1.
    - The first edge with memWait=0 completes the write, so memWE is high for exactly one un-stalled cycle.
    - Next: load response 0x06, go to RSP.
  - RD: vaddr=addr, memWE=0, byteena=0, busActive=1.
    - Latency counter increments only on cycles with memWait=0.
    - On the edge where the counter reaches READ_LATENCY, q is latched and the block goes to RSP with 4 response bytes.
  - RSP: send the bytes in order. For each byte:
    - Wait until txBusy=0 and the gap counter is 0.
    - Drive txData and pulse txWE for 1 cycle.
    - Gap counter loads TX_GAP.
    - After the last pulse -> IDLE.
- NAK: enters RSP directly from IDLE with a single byte, 0x15.
- Timeout:
  - In ADDR/DATA, a counter clears on every rxValid.
  - When it reaches TIMEOUT-1, the block goes to IDLE, discards the partial frame and sends no response.
- Overrun:
  - rxValid in WR/RD/RSP drops the byte and sets errOverrun.
  - errOverrun clears only by reset.
- busActive is 0 outside WR/RD. vaddr/data hold their last value outside WR/RD. memWE is 0 outside WR.
- Minimum frame-to-response latency for W: 1 cycle after the last data byte, with memWait=0 and txBusy=0.
- Address arithmetic: none. The address is passed verbatim and may target MMIO (e.g. 0x200..0x202).

Decomposition:
- Package uart_mem_pkg:
  - constants OP_WRITE=8'h57, OP_READ=8'h52, RSP_ACK=8'h06, RSP_NAK=8'h15
  - state enum typedef
- Sub-module uart_byte_sender: owns the response shift register, gap counter and txBusy handshake. Loaded with count (1 or 4) and a 32-bit word; signals done.

Test Plan:
- Write: bytes 57 00 01 00 00 EF BE AD DE -> one cycle vaddr=0x00000100, data=0xDEADBEEF, byteena=F, memWE=1, then txData=0x06 pulsed once.
- Read: bytes 52 00 01 00 00, model returns q=0xDEADBEEF 3 cycles after vaddr -> tx sequence EF BE AD DE, with each txWE issued only after txBusy falls.
- Stall: memWait held high 5 cycles during WR -> memWE/vaddr/data stable all 6 cycles, exactly one write commits, ACK follows.
- Bad opcode 0x41 -> tx 0x15, state IDLE. A following valid read frame is served normally.
- Timeout: bytes 57 00 01, then silence for TIMEOUT cycles -> no tx, no memWE. Next frame 52 ... is decoded as fresh.
- Overrun plus reset: byte sent during RSP -> errOverrun=1. Async RST low mid-RD -> busActive=0, txWE=0, errOverrun=0 immediately.
